// File: rtl/ps2_key_tracker.sv
// PS/2 scancode tracker: pops FIFO bytes, decodes E0/F0 make/break, renders byte history as hex.
// Define KEY_HIST_PREFIX_FILTER_EN to keep E0/F0 prefix bytes out of the history.
module ps2_key_tracker #(
  parameter int unsigned HIST_DEPTH = 3,
  parameter int unsigned COUNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              data_i,
  input  logic                    ready_i,
  input  logic                    overflow_i,
  output logic                    nextdata_n_o,
  output logic [14*HIST_DEPTH-1:0] hex_o,
  output logic                    key_down_o,
  output logic [7:0]              key_code_o,
  output logic                    key_ext_o,
  output logic [COUNT_W-1:0]      press_count_o,
  output logic                    err_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPop  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  localparam logic [7:0] PrefixExt = 8'hE0;
  localparam logic [7:0] PrefixBrk = 8'hF0;

  logic [1:0]                 state_q, state_d;
  logic [7:0]                 byte_q, byte_d;
  logic                       ndn_q, ndn_d;
  logic                       down_q, down_d;
  logic [7:0]                 code_q, code_d;
  logic                       ext_q, ext_d;
  logic [COUNT_W-1:0]         cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic                       ext_pend_q, ext_pend_d;
  logic                       brk_pend_q, brk_pend_d;
  logic [HIST_DEPTH-1:0][7:0] hist_q, hist_d;
  logic [HIST_DEPTH-1:0]      valid_q, valid_d;
  logic                       is_code;
  logic                       shift;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign is_code = (byte_q != PrefixExt) && (byte_q != PrefixBrk);

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    ndn_d      = 1'b1;
    down_d     = down_q;
    code_d     = code_q;
    ext_d      = ext_q;
    cnt_d      = cnt_q;
    err_d      = err_q | overflow_i;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    hist_d     = hist_q;
    valid_d    = valid_q;
    shift      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ready_i) begin
          byte_d  = data_i;
          state_d = StPop;
          ndn_d   = 1'b0;
        end
      end
      StPop: begin
        state_d = StWait;
        if (byte_q == PrefixExt) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == PrefixBrk) begin
          brk_pend_d = 1'b1;
        end else begin
          if (brk_pend_q) begin
            // A break for a key other than the held one leaves key_down alone.
            if (byte_q == code_q) down_d = 1'b0;
          end else begin
            if (!down_q || (byte_q != code_q)) cnt_d = cnt_q + COUNT_W'(1);
            down_d = 1'b1;
            code_d = byte_q;
            ext_d  = ext_pend_q;
          end
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
`ifdef KEY_HIST_PREFIX_FILTER_EN
        shift = is_code;
`else
        shift = 1'b1;
`endif
      end
      StWait: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (shift) begin
      for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) begin
        hist_d[i]  = hist_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      hist_d[0]  = byte_q;
      valid_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_q     <= 8'h00;
      ndn_q      <= 1'b1;
      down_q     <= 1'b0;
      code_q     <= 8'h00;
      ext_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      hist_q     <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      ndn_q      <= ndn_d;
      down_q     <= down_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      hist_q     <= hist_d;
      valid_q    <= valid_d;
    end
  end

  // Slot s: low nibble on digit 2s, high nibble on digit 2s+1; unfilled slots blank.
  always_comb begin
    hex_o = '1;
    for (int s = 0; s < int'(HIST_DEPTH); s++) begin
      if (valid_q[s]) begin
        hex_o[14*s +: 7]     = hex_glyph(hist_q[s][3:0]);
        hex_o[14*s + 7 +: 7] = hex_glyph(hist_q[s][7:4]);
      end
    end
  end

  assign nextdata_n_o  = ndn_q;
  assign key_down_o    = down_q;
  assign key_code_o    = code_q;
  assign key_ext_o     = ext_q;
  assign press_count_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: behavioural model plus directed literal checks.
module tb_ps2_key_tracker;

  localparam int D  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          ready = 1'b0;
  logic          overflow = 1'b0;
  logic          ndn;
  logic [14*D-1:0] hex;
  logic          key_down;
  logic [7:0]    key_code;
  logic          key_ext;
  logic [CW-1:0] press_count;
  logic          err;

  int total = 0;
  int bad   = 0;

  ps2_key_tracker #(.HIST_DEPTH(D), .COUNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data),
    .ready_i      (ready),
    .overflow_i   (overflow),
    .nextdata_n_o (ndn),
    .hex_o        (hex),
    .key_down_o   (key_down),
    .key_code_o   (key_code),
    .key_ext_o    (key_ext),
    .press_count_o(press_count),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Seven-segment glyphs, active-low, bit0 = a.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: phase counts position within the 3-cycle consume window.
  int            m_phase = 0;
  logic [7:0]    m_byte = 8'h00;
  logic          m_ndn = 1'b1;
  logic          m_down = 1'b0;
  logic [7:0]    m_code = 8'h00;
  logic          m_ext = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_err = 1'b0;
  logic          m_ep = 1'b0;
  logic          m_bp = 1'b0;
  logic [7:0]    hq[$];

  task automatic model_consume(input logic [7:0] b);
    logic code;
    code = (b != 8'hE0) && (b != 8'hF0);
    if (b == 8'hE0) m_ep = 1'b1;
    else if (b == 8'hF0) m_bp = 1'b1;
    else begin
      if (m_bp) begin
        if (b == m_code) m_down = 1'b0;
      end else begin
        if (!m_down || b != m_code) m_cnt = m_cnt + 1'b1;
        m_down = 1'b1;
        m_code = b;
        m_ext  = m_ep;
      end
      m_ep = 1'b0;
      m_bp = 1'b0;
    end
`ifdef KEY_HIST_PREFIX_FILTER_EN
    if (code) hq.push_front(b);
`else
    hq.push_front(b);
`endif
    if (hq.size() > D) void'(hq.pop_back());
  endtask

  function automatic logic [14*D-1:0] model_hex();
    logic [14*D-1:0] h;
    h = '1;
    for (int s = 0; s < D; s++) begin
      if (s < hq.size()) begin
        h[14*s +: 7]     = glyph[hq[s][3:0]];
        h[14*s + 7 +: 7] = glyph[hq[s][7:4]];
      end
    end
    return h;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_ndn = 1'b1; m_down = 1'b0; m_code = 8'h00; m_ext = 1'b0;
      m_cnt = '0; m_err = 1'b0; m_ep = 1'b0; m_bp = 1'b0;
      hq.delete();
    end else begin
      if (overflow) m_err = 1'b1;
      if (m_phase == 0) begin
        if (ready) begin
          m_byte  = data;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        model_consume(m_byte);
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
      m_ndn = (m_phase != 1);
    end
  end

  always @(negedge clk) begin
    check("nextdata_n", 64'(ndn), 64'(m_ndn));
    check("key_down", 64'(key_down), 64'(m_down));
    check("key_code", 64'(key_code), 64'(m_code));
    check("key_ext", 64'(key_ext), 64'(m_ext));
    check("press_count", 64'(press_count), 64'(m_cnt));
    check("err", 64'(err), 64'(m_err));
    check("hex", 64'(hex), 64'(model_hex()));
  end

  task automatic send(input logic [7:0] b);
    ready = 1'b1;
    data  = b;
    @(posedge clk); #1;
    ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int nlow;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_hex", 64'(hex), 64'({(2*D){7'h7F}}));
    check("rst_ndn", 64'(ndn), 64'd1);
    check("rst_cnt", 64'(press_count), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // Typematic: ready held for 12 cycles with the same code.
    ready = 1'b1; data = 8'h1C; nlow = 0;
    repeat (12) begin
      @(negedge clk);
      if (!ndn) nlow++;
    end
    @(posedge clk); #1 ready = 1'b0;
    @(posedge clk); #1;
    check("typ_pops", 64'(nlow), 64'd4);
    check("typ_code", 64'(key_code), 64'h1C);
    check("typ_cnt", 64'(press_count), 64'd1);
    check("typ_down", 64'(key_down), 64'd1);

    do_reset();
    send(8'h1C); send(8'hF0); send(8'h1C);
    check("brk_down", 64'(key_down), 64'd0);
    check("brk_cnt", 64'(press_count), 64'd1);
    check("brk_d0", 64'(hex[6:0]), 64'h46);
    check("brk_d1", 64'(hex[13:7]), 64'h79);
`ifdef KEY_HIST_PREFIX_FILTER_EN
    check("brk_d2", 64'(hex[20:14]), 64'h46);
    check("brk_d3", 64'(hex[27:21]), 64'h79);
    check("brk_d54", 64'(hex[41:28]), 64'h3FFF);
`else
    check("brk_d2", 64'(hex[20:14]), 64'h40);
    check("brk_d3", 64'(hex[27:21]), 64'h0E);
    check("brk_d4", 64'(hex[34:28]), 64'h46);
`endif

    send(8'hE0); send(8'h75);
    check("ext_flag", 64'(key_ext), 64'd1);
    check("ext_code", 64'(key_code), 64'h75);
    check("ext_cnt", 64'(press_count), 64'd2);
    check("ext_d0", 64'(hex[6:0]), 64'h12);
    check("ext_d1", 64'(hex[13:7]), 64'h78);
    send(8'h1C);
    check("noext_flag", 64'(key_ext), 64'd0);
    check("noext_cnt", 64'(press_count), 64'd3);

    overflow = 1'b1;
    @(posedge clk); #1 overflow = 1'b0;
    check("ovf_err", 64'(err), 64'd1);
    send(8'h2A); send(8'hF0); send(8'h2A);
    check("ovf_sticky", 64'(err), 64'd1);

    // Reset asserted while the FSM sits in POP.
    ready = 1'b1; data = 8'h33;
    @(posedge clk); #1;
    ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rpop_ndn", 64'(ndn), 64'd1);
    check("rpop_cnt", 64'(press_count), 64'd0);
    check("rpop_err", 64'(err), 64'd0);
    check("rpop_down", 64'(key_down), 64'd0);
    check("rpop_hex", 64'(hex), 64'({(2*D){7'h7F}}));
    @(posedge clk); #1 rst = 1'b0;
    send(8'h1C);
    check("rpost_cnt", 64'(press_count), 64'd1);
    check("rpost_code", 64'(key_code), 64'h1C);

    // 257 alternating makes wrap an 8-bit counter to 1.
    do_reset();
    for (int i = 0; i < 257; i++) send(i[0] ? 8'h1D : 8'h1C);
    check("wrap_cnt", 64'(press_count), 64'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 scancode tracker between the PS/2 receiver FIFO (byte data, ready, overflow, active-low nextdata_n pop) and the board seven-segment bank. Pops bytes through a three-state handshake FSM, decodes E0/F0 prefixes into make/break events, tracks the held key and a press counter, and keeps an N-byte history rendered as 2·HIST_DEPTH hex digits with blanking of unfilled slots.

## Interface
- HIST_DEPTH, 3: number of history bytes; digit count is 2·HIST_DEPTH.
- COUNT_W, 8: width of the press counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  8  byte at the head of the receiver FIFO.
- ready  in  1  FIFO non-empty.
- overflow  in  1  FIFO overflow flag.
- nextdata_n  out  1  active-low pop strobe to the FIFO.
- hex  out  14·HIST_DEPTH  packed digits; digit k is hex[7k+6:7k], active-low, bit0 = segment a … bit6 = segment g.
- key_down  out  1  a key is currently held.
- key_code  out  8  last make code (prefixes excluded).
- key_ext  out  1  last make code was E0-prefixed.
- press_count  out  COUNT_W  number of distinct presses, wrapping modulo 2^COUNT_W.
- err  out  1  sticky overflow indicator.

## Operation
- Reset values: nextdata_n=1, key_down=0, key_code=0, key_ext=0, press_count=0, err=0, all history slots invalid, every hex digit 7'h7F (blank), FSM in IDLE, prefix flags clear.
- FSM states:
  - IDLE: nextdata_n=1. If ready=1, capture data into the byte register and go to POP.
  - POP: nextdata_n=0 for exactly this cycle; process the captured byte; go to WAIT.
  - WAIT: nextdata_n=1; ready is ignored; go to IDLE.
- Byte processing in POP:
  - 0xE0: set ext_pend.
  - 0xF0: set brk_pend.
  - Any other byte is a code. If brk_pend is set, it is a break: if the code equals key_code, key_down←0; otherwise key_down is unchanged. If brk_pend is clear, it is a make: if key_down=0 or the code ≠ key_code, press_count increments; a repeated make of the held code (typematic) does not increment. In both cases key_down←1, key_code←code, key_ext←ext_pend. Both prefix flags clear after any code byte.
- History is a shift register; slot 0 is newest. A shift moves slot i into slot i+1, drops the oldest slot, and marks slot 0 valid.
- Digit mapping: slot s low nibble drives digit 2s, high nibble drives digit 2s+1. Standard hex glyphs: 0→7'h40, 1→7'h79, C→7'h46, F→7'h0E, 5→7'h12, 7→7'h78. Invalid slots show 7'h7F on both digits.
- err is set in any cycle with overflow=1 and is cleared only by rst.

## Timing
- One byte is consumed per three cycles at most (IDLE→POP→WAIT). WAIT covers the FIFO's one-cycle ready update after a pop.
- Outputs update at the clock edge that ends POP, so they are visible in the WAIT cycle, one cycle after the pop strobe. Latency from ready rising in IDLE to the outputs changing is 2 edges.
- All outputs are registered; hex is combinational from registered history only.
- If rst is asserted during POP or WAIT, state returns immediately to reset values. The byte in flight may or may not have been popped from the FIFO; its loss is accepted.
- If overflow and a pop occur in the same cycle, both take effect.
- press_count wraps from 2^COUNT_W−1 to 0.

## Configuration
- KEY_HIST_PREFIX_FILTER_EN defined: only code bytes shift into history. Sequence F0 1C adds one entry, 1C.
- Not defined: every popped byte, including E0 and F0, shifts into history. The same sequence adds F0, then 1C.
- Decode, counter and handshake behaviour are identical in both builds.

## Test plan
- Reset: after rst, hex = all 7'h7F, nextdata_n=1, press_count=0, err=0.
- Hold ready=1 for 12 cycles with data 1C → nextdata_n low for exactly one cycle out of every 3 (4 pops); key_code=0x1C, press_count=1 (later pops are typematic), key_down=1.
- Sequence 1C, F0, 1C → key_down=0, press_count=1. History with filter: digits 1:0 = "1C", digits 3:2 = "1C", digits 5:4 blank. Without filter: newest-first 1C, F0, 1C.
- Sequence E0, 75 → key_ext=1, key_code=0x75, press_count increments. Then 1C → key_ext=0, count increments again.
- Pulse overflow for one cycle → err=1, and err stays 1 through subsequent traffic until rst.
- Assert rst during POP → all outputs return to reset values on the same edge. After release, the next ready is handled from IDLE.
